// File: rtl/aes_pkg.sv
// Shared AES round-controller definitions: FSM states, key-length codes,
// default round counts and the key-length to round-count mapping.
package aes_pkg;

   // FSM states of the round controller; 3'd7 is the only illegal code
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_SUB  = 3'd2,
      S_ROW  = 3'd3,
      S_COL  = 3'd4,
      S_ARK  = 3'd5,
      S_OUT  = 3'd6
   } state_t;

   // key_len encodings
   localparam logic [1:0] KL_128  = 2'b00;
   localparam logic [1:0] KL_192  = 2'b01;
   localparam logic [1:0] KL_256  = 2'b10;
   localparam logic [1:0] KL_RSVD = 2'b11;

   // default round counts
   localparam int NR_128_DFLT = 10;
   localparam int NR_192_DFLT = 12;
   localparam int NR_256_DFLT = 14;

   // Round count for a key length; the reserved code falls back to AES-128
   function automatic int nr_for_key_len(input logic [1:0] key_len,
                                         input int nr128,
                                         input int nr192,
                                         input int nr256);
      case (key_len)
         KL_192:  return nr192;
         KL_256:  return nr256;
         default: return nr128;
      endcase
   endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Round counter with synchronous clear/increment, the latched round count
// for the current operation and the last-round flag.
module aes_round_cnt
   import aes_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic [CNT_W-1:0] i_nr,
   output logic [CNT_W-1:0] o_r,
   output logic [CNT_W-1:0] o_nr,
   output logic             o_last
);

   logic [CNT_W-1:0] r_r;
   logic [CNT_W-1:0] r_nr;

   // Clear loads the new round count; increment steps to the next round
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_r  <= '0;
         r_nr <= '0;
      end else if (i_clr) begin
         r_r  <= '0;
         r_nr <= i_nr;
      end else if (i_inc) begin
         r_r  <= r_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_r    = r_r;
   assign o_nr   = r_nr;
   assign o_last = (r_r == r_nr);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: walks LOAD and then SUB/ROW/COL/ARK per round in
// encrypt or decrypt order and drives Moore-decoded datapath strobes.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR_128 = NR_128_DFLT,
   parameter int NR_192 = NR_192_DFLT,
   parameter int NR_256 = NR_256_DFLT,
   parameter int CNT_W  = 4
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_decrypt,
   input  logic [1:0]       i_key_len,
   input  logic             i_abort,
   input  logic             i_out_ready,
   output logic             o_busy,
   output logic             o_init,
   output logic             o_is_round0,
   output logic             o_en_sub,
   output logic             o_en_row,
   output logic             o_en_col,
   output logic             o_en_ark,
   output logic             o_en_dout,
   output logic             o_inv,
   output logic [CNT_W-1:0] o_key_idx,
   output logic             o_out_valid,
   output logic             o_cfg_err
);

   state_t           r_state;
   state_t           w_next_state;
   logic             r_inv;
   logic             w_can_start;
   logic             w_accept;
   logic             w_inc;
   logic [CNT_W-1:0] w_r;
   logic [CNT_W-1:0] w_nr;
   logic             w_last;
   logic [CNT_W-1:0] w_nr_sel;

   assign w_nr_sel = CNT_W'(nr_for_key_len(i_key_len, NR_128, NR_192, NR_256));

   aes_round_cnt #(.CNT_W(CNT_W)) u_round_cnt (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_clr   (w_accept),
      .i_inc   (w_inc),
      .i_nr    (w_nr_sel),
      .o_r     (w_r),
      .o_nr    (w_nr),
      .o_last  (w_last)
   );

   // State register
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Mode latch: sampled only when a new operation is accepted
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_inv <= 1'b0;
      end else if (w_accept) begin
         r_inv <= i_decrypt;
      end else begin
         r_inv <= r_inv;
      end
   end

   // Next-state, round-counter control and Moore strobe decode
   always_comb begin
      w_next_state = r_state;
      w_can_start  = 1'b0;
      w_inc        = 1'b0;
      o_is_round0  = 1'b0;
      o_en_sub     = 1'b0;
      o_en_row     = 1'b0;
      o_en_col     = 1'b0;
      o_en_ark     = 1'b0;
      o_en_dout    = 1'b0;
      o_out_valid  = 1'b0;
      o_key_idx    = '0;
      case (r_state)
         S_IDLE: begin
            w_can_start = 1'b1;
         end
         S_LOAD: begin
            o_is_round0  = 1'b1;
            o_en_ark     = 1'b1;
            w_inc        = 1'b1;
            o_key_idx    = r_inv ? w_nr : {CNT_W{1'b0}};
            w_next_state = r_inv ? S_ROW : S_SUB;
         end
         S_SUB: begin
            o_en_sub     = 1'b1;
            w_next_state = r_inv ? S_ARK : S_ROW;
         end
         S_ROW: begin
            o_en_row = 1'b1;
            if (r_inv) begin
               w_next_state = S_SUB;
            end else begin
               w_next_state = w_last ? S_ARK : S_COL;
            end
         end
         S_COL: begin
            o_en_col = 1'b1;
            // decrypt rounds end on COL, encrypt rounds continue to ARK
            if (r_inv) begin
               w_inc        = 1'b1;
               w_next_state = S_ROW;
            end else begin
               w_next_state = S_ARK;
            end
         end
         S_ARK: begin
            o_en_ark  = 1'b1;
            o_key_idx = r_inv ? (w_nr - w_r) : w_r;
            if (w_last) begin
               o_en_dout    = 1'b1;
               w_next_state = S_OUT;
            end else if (r_inv) begin
               w_next_state = S_COL;
            end else begin
               w_inc        = 1'b1;
               w_next_state = S_SUB;
            end
         end
         S_OUT: begin
            o_out_valid = 1'b1;
            w_can_start = i_out_ready;
            if (i_out_ready) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_OUT;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase

      w_accept = w_can_start && i_start && !i_abort && !i_reset;

      // abort wins over everything, including a start in the same cycle
      if (i_abort) begin
         w_next_state = S_IDLE;
         w_inc        = 1'b0;
      end else if (w_accept) begin
         w_next_state = S_LOAD;
      end else begin
         w_next_state = w_next_state;
      end
   end

   assign o_busy    = (r_state != S_IDLE);
   assign o_inv     = r_inv;
   assign o_init    = w_accept;
   assign o_cfg_err = w_accept && (i_key_len == KL_RSVD);

endmodule
